// File: rtl/alu_seq_if.sv
// Handshake, memory-read and ALU-side signals of the ALU sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_seq_if #(
   parameter int DATA_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_op;
   logic [11:0]       cmd_addr;
   logic              mem_rd;
   logic [11:0]       mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] inpr;
   logic [6:0]        alu_sel;
   logic [DATA_W-1:0] alu_dr;
   logic [DATA_W:0]   alu_out;
   logic [DATA_W-1:0] ac;
   logic              e;
   logic              done;
   logic              err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, mem_ack, mem_data, inpr, alu_out,
      input  cmd_ready, mem_rd, mem_addr, alu_sel, alu_dr, ac, e, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, mem_ack, mem_data, inpr, alu_out,
      output cmd_ready, mem_rd, mem_addr, alu_sel, alu_dr, ac, e, done, err
   );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the hardwired CPU's add/logic unit: fetches a
// memory operand into DR when needed, fires the ALU select once, commits AC/E.
module alu_sequencer #(
   parameter int DATA_W = 16
) (
   input logic     clk,
   input logic     rst,
   alu_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      EX   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        op;
   logic [11:0]       addr;
   logic [DATA_W-1:0] dr;
   logic [DATA_W-1:0] ac;
   logic              e;
   logic              done;
   logic              err;
   logic              accept;
   logic [6:0]        sel;

   assign accept = (state == IDLE) && bus.cmd_valid;

   always_comb begin
      state_nxt = state;
      sel       = 7'b0000000;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_nxt = (bus.cmd_op <= 4'd2) ? RD : EX;
            end
         end
         RD: begin
            if (bus.mem_ack) begin
               state_nxt = EX;
            end
         end
         EX: begin
            state_nxt = IDLE;
            case (op)
               4'd0:    sel = 7'b0000001;
               4'd1:    sel = 7'b0000010;
               4'd2:    sel = 7'b0000100;
               4'd3:    sel = 7'b0001000;
               4'd4:    sel = 7'b0010000;
               4'd5:    sel = 7'b0100000;
               4'd6:    sel = 7'b1000000;
               default: sel = 7'b0000000;
            endcase
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op    <= 4'd0;
         addr  <= 12'd0;
         dr    <= '0;
         ac    <= '0;
         e     <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         err   <= 1'b0;
         if (accept) begin
            op   <= bus.cmd_op;
            addr <= bus.cmd_addr;
         end
         if (state == RD && bus.mem_ack) begin
            dr <= bus.mem_data;
         end
         // Commit on the edge that closes EX; done/err are visible in the following IDLE cycle.
         if (state == EX) begin
            done <= 1'b1;
            case (op)
               4'd0, 4'd2, 4'd3, 4'd4: ac <= bus.alu_out[DATA_W-1:0];
               4'd1, 4'd5, 4'd6: begin
                  ac <= bus.alu_out[DATA_W-1:0];
                  e  <= bus.alu_out[DATA_W];
               end
               4'd7:    ac  <= '0;
               4'd8:    e   <= 1'b0;
               4'd9:    e   <= ~e;
               4'd10:   ac  <= ac + DATA_W'(1);
               default: err <= 1'b1;
            endcase
         end
      end
   end

   assign bus.cmd_ready = (state == IDLE);
   assign bus.mem_rd    = (state == RD);
   assign bus.mem_addr  = addr;
   assign bus.alu_sel   = sel;
   assign bus.alu_dr    = dr;
   assign bus.ac        = ac;
   assign bus.e         = e;
   assign bus.done      = done;
   assign bus.err       = err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with a behavioral ALU feeding alu_out.
module tb_alu_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_seq_if #(.DATA_W(16)) bus ();

   alu_sequencer #(.DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioral ALU; rotates go through E.
   always_comb begin
      bus.alu_out = 17'd0;
      case (bus.alu_sel)
         7'b0000001: bus.alu_out = {1'b0, bus.ac & bus.alu_dr};
         7'b0000010: bus.alu_out = {1'b0, bus.ac} + {1'b0, bus.alu_dr};
         7'b0000100: bus.alu_out = {1'b0, bus.alu_dr};
         7'b0001000: bus.alu_out = {1'b0, bus.inpr};
         7'b0010000: bus.alu_out = {1'b0, ~bus.ac};
         7'b0100000: bus.alu_out = {bus.ac[0], bus.e, bus.ac[15:1]};
         7'b1000000: bus.alu_out = {bus.ac[15], bus.ac[14:0], bus.e};
         default:    bus.alu_out = 17'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [11:0] addr);
      int t = 0;
      while (!bus.cmd_ready && t < 20) begin
         step();
         t++;
      end
      check("cmd_ready_wait", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      step();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 4'hF;
      bus.cmd_addr  = 12'hFFF;
   endtask

   task automatic run_mem(input string tag, input logic [3:0] op, input logic [11:0] addr,
                          input int k, input logic [15:0] data, input logic [6:0] exp_sel,
                          input logic [15:0] exp_ac, input logic exp_e);
      issue(op, addr);
      for (int i = 0; i < k; i++) begin
         check({tag, "_mem_rd_hi"}, bus.mem_rd, 1'b1);
         check({tag, "_mem_addr"}, bus.mem_addr, addr);
         check({tag, "_sel_rd"}, bus.alu_sel, 7'd0);
         if (i == k - 1) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = data;
         end
         step();
         bus.mem_ack  = 1'b0;
         bus.mem_data = 16'hDEAD;
      end
      check({tag, "_mem_rd_lo"}, bus.mem_rd, 1'b0);
      check({tag, "_sel_ex"}, bus.alu_sel, exp_sel);
      check({tag, "_done_ex"}, bus.done, 1'b0);
      step();
      check({tag, "_done"}, bus.done, 1'b1);
      check({tag, "_err"}, bus.err, 1'b0);
      check({tag, "_ac"}, bus.ac, exp_ac);
      check({tag, "_e"}, bus.e, exp_e);
      check({tag, "_dr"}, bus.alu_dr, data);
      check({tag, "_sel_idle"}, bus.alu_sel, 7'd0);
      step();
      check({tag, "_done_pulse"}, bus.done, 1'b0);
   endtask

   task automatic run_reg(input string tag, input logic [3:0] op, input logic [6:0] exp_sel,
                          input logic [15:0] exp_ac, input logic exp_e, input logic exp_err);
      issue(op, 12'h000);
      check({tag, "_mem_rd"}, bus.mem_rd, 1'b0);
      check({tag, "_sel_ex"}, bus.alu_sel, exp_sel);
      check({tag, "_done_ex"}, bus.done, 1'b0);
      check({tag, "_busy"}, bus.cmd_ready, 1'b0);
      step();
      check({tag, "_done"}, bus.done, 1'b1);
      check({tag, "_err"}, bus.err, exp_err);
      check({tag, "_ac"}, bus.ac, exp_ac);
      check({tag, "_e"}, bus.e, exp_e);
      check({tag, "_sel_idle"}, bus.alu_sel, 7'd0);
      check({tag, "_ready"}, bus.cmd_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 4'd2;
      bus.cmd_addr  = 12'h456;
      bus.mem_ack   = 1'b0;
      bus.mem_data  = 16'h0000;
      bus.inpr      = 16'h1234;

      // Reset with a pending request: nothing may be accepted.
      step();
      step();
      check("rst_ready", bus.cmd_ready, 1'b1);
      check("rst_mem_rd", bus.mem_rd, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 12'h000);
      check("rst_sel", bus.alu_sel, 7'd0);
      check("rst_dr", bus.alu_dr, 16'h0000);
      check("rst_ac", bus.ac, 16'h0000);
      check("rst_e", bus.e, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_err", bus.err, 1'b0);
      bus.cmd_valid = 1'b0;
      rst = 1'b0;
      step();
      check("post_rst_ready", bus.cmd_ready, 1'b1);
      check("post_rst_mem_rd", bus.mem_rd, 1'b0);

      run_mem("lda", 4'd2, 12'h123, 3, 16'h8001, 7'b0000100, 16'h8001, 1'b0);

      run_reg("cla0", 4'd7, 7'b0000000, 16'h0000, 1'b0, 1'b0);
      run_reg("cma0", 4'd4, 7'b0010000, 16'hFFFF, 1'b0, 1'b0);
      run_mem("add", 4'd1, 12'h0F0, 2, 16'h0002, 7'b0000010, 16'h0001, 1'b1);

      run_reg("cle", 4'd8, 7'b0000000, 16'h0001, 1'b0, 1'b0);
      run_reg("cla1", 4'd7, 7'b0000000, 16'h0000, 1'b0, 1'b0);
      run_reg("cma1", 4'd4, 7'b0010000, 16'hFFFF, 1'b0, 1'b0);
      run_reg("cme", 4'd9, 7'b0000000, 16'hFFFF, 1'b1, 1'b0);
      run_reg("inc", 4'd10, 7'b0000000, 16'h0000, 1'b1, 1'b0);

      run_reg("inp", 4'd3, 7'b0001000, 16'h1234, 1'b1, 1'b0);
      run_reg("cil", 4'd6, 7'b1000000, 16'h2469, 1'b0, 1'b0);
      run_reg("cir", 4'd5, 7'b0100000, 16'h1234, 1'b1, 1'b0);
      run_mem("and", 4'd0, 12'h7FF, 1, 16'h0FF0, 7'b0000001, 16'h0230, 1'b1);

      // cmd_valid held high: CLA, CMA, then illegal 0xC, accepted every 2 cycles.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 4'd7;
      check("b2b_ready0", bus.cmd_ready, 1'b1);
      step();
      bus.cmd_op = 4'd4;
      check("b2b_busy0", bus.cmd_ready, 1'b0);
      step();
      check("b2b_done0", bus.done, 1'b1);
      check("b2b_ac0", bus.ac, 16'h0000);
      check("b2b_ready1", bus.cmd_ready, 1'b1);
      step();
      bus.cmd_op = 4'hC;
      check("b2b_busy1", bus.cmd_ready, 1'b0);
      check("b2b_sel1", bus.alu_sel, 7'b0010000);
      step();
      check("b2b_done1", bus.done, 1'b1);
      check("b2b_ac1", bus.ac, 16'hFFFF);
      check("b2b_ready2", bus.cmd_ready, 1'b1);
      step();
      bus.cmd_valid = 1'b0;
      check("b2b_sel2", bus.alu_sel, 7'd0);
      step();
      check("b2b_done2", bus.done, 1'b1);
      check("b2b_err2", bus.err, 1'b1);
      check("b2b_ac2", bus.ac, 16'hFFFF);
      check("b2b_e2", bus.e, 1'b1);
      check("b2b_dr2", bus.alu_dr, 16'h0FF0);
      step();
      check("b2b_err_pulse", bus.err, 1'b0);

      // Reset during the RD wait, then a late ack that must be ignored.
      issue(4'd2, 12'h0AA);
      check("rrd_mem_rd0", bus.mem_rd, 1'b1);
      step();
      check("rrd_mem_rd1", bus.mem_rd, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rrd_mem_rd_lo", bus.mem_rd, 1'b0);
      check("rrd_done", bus.done, 1'b0);
      check("rrd_ac", bus.ac, 16'h0000);
      check("rrd_ready", bus.cmd_ready, 1'b1);
      bus.mem_ack  = 1'b1;
      bus.mem_data = 16'h5555;
      step();
      bus.mem_ack = 1'b0;
      check("rrd_late_done", bus.done, 1'b0);
      check("rrd_late_mem_rd", bus.mem_rd, 1'b0);
      check("rrd_late_ac", bus.ac, 16'h0000);
      check("rrd_late_dr", bus.alu_dr, 16'h0000);
      check("rrd_late_ready", bus.cmd_ready, 1'b1);
      step();
      check("rrd_late_done2", bus.done, 1'b0);
      check("rrd_late_sel", bus.alu_sel, 7'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
